// File: rtl/rastreador_execucao_riscv_if.sv
// rtl/rastreador_execucao_riscv_if.sv - snoop inputs and trace output stream of the execution tracer
// Snoop side : pc, escrever_registrador, registrador_destino, dados_escrita
// Output side: saida_valida, saida_pronta, saida_pc, saida_rd, saida_dado
// master = datapath/consumer side, slave = tracer side
interface rastreador_execucao_riscv_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic [XLEN-1:0]       pc;
  logic                  escrever_registrador;
  logic [REG_ADDR_W-1:0] registrador_destino;
  logic [XLEN-1:0]       dados_escrita;
  logic                  saida_valida;
  logic                  saida_pronta;
  logic [XLEN-1:0]       saida_pc;
  logic [REG_ADDR_W-1:0] saida_rd;
  logic [XLEN-1:0]       saida_dado;

  modport master (
    output pc, escrever_registrador, registrador_destino, dados_escrita, saida_pronta,
    input  saida_valida, saida_pc, saida_rd, saida_dado
  );

  modport slave (
    input  pc, escrever_registrador, registrador_destino, dados_escrita, saida_pronta,
    output saida_valida, saida_pc, saida_rd, saida_dado
  );
endinterface

// File: rtl/rastreador_execucao_riscv.sv
// rtl/rastreador_execucao_riscv.sv - execution tracer: buffers non-x0 writebacks, counts, detects halt
// clk, reset_n (async, active low)
// habilitar          : enable capture      modo_sobrescrever : 0 drop when full, 1 overwrite oldest
// bus (slave)        : snoop inputs + first-word-fall-through trace stream
// ocupacao           : entries stored      contador_ciclos/escritas : saturating counters
// transbordou        : sticky loss flag    parado : halt detected
module rastreador_execucao_riscv #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       habilitar,
  input  logic                       modo_sobrescrever,
  rastreador_execucao_riscv_if.slave bus,
  output logic [$clog2(DEPTH):0]     ocupacao,
  output logic [CNT_W-1:0]           contador_ciclos,
  output logic [CNT_W-1:0]           contador_escritas,
  output logic                       transbordou,
  output logic                       parado
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(HALT_CYCLES + 1);
  localparam int EW = 2 * XLEN + REG_ADDR_W;
  localparam logic [AW:0] OCUP_MAX = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {OCIOSO, CAPTURANDO, PARADO} estado_t;

  estado_t          estado_q;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      ocup_q, ocup_d;
  logic [EW-1:0]    cabeca_q, cabeca_d;
  logic [CNT_W-1:0] ciclos_q, escritas_q;
  logic             transbordou_q, parado_q;
  logic [XLEN-1:0]  pc_anterior_q;
  logic             pc_valido_q;
  logic [RW-1:0]    repeticoes_q, repeticoes_d;

  logic capturando, iniciar, evt, cheia, pop, push, sobrescreve, descarta, halt;
  logic [EW-1:0] entrada;

  assign capturando  = (estado_q == CAPTURANDO);
  assign iniciar     = (estado_q == OCIOSO) && habilitar;
  assign evt         = capturando && bus.escrever_registrador && (bus.registrador_destino != '0);
  assign cheia       = (ocup_q == OCUP_MAX);
  assign pop         = (ocup_q != '0) && bus.saida_pronta;
  // When full, a push only lands if a pop frees a slot or overwrite mode evicts the oldest.
  assign push        = evt && (!cheia || pop || modo_sobrescrever);
  assign sobrescreve = evt && cheia && !pop && modo_sobrescrever;
  assign descarta    = evt && cheia && !pop && !modo_sobrescrever;
  assign entrada     = {bus.pc, bus.registrador_destino, bus.dados_escrita};
  // pc_valido_q gates the very first capture cycle so it always counts as a change.
  assign repeticoes_d = (pc_valido_q && (bus.pc == pc_anterior_q)) ? repeticoes_q + RW'(1) : '0;
  assign halt         = capturando && (repeticoes_d == RW'(HALT_CYCLES));

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = (pop || sobrescreve) ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ocup_d   = ocup_q;
    if (push && !pop && !sobrescreve) ocup_d = ocup_q + (AW + 1)'(1);
    else if (pop && !push)            ocup_d = ocup_q - (AW + 1)'(1);
    // Next head: bypass the entry being written when it becomes the head this edge.
    cabeca_d = (push && (rd_ptr_d == wr_ptr_q)) ? entrada : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entrada;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= OCIOSO;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ocup_q        <= '0;
      cabeca_q      <= '0;
      ciclos_q      <= '0;
      escritas_q    <= '0;
      transbordou_q <= 1'b0;
      parado_q      <= 1'b0;
      pc_anterior_q <= '0;
      pc_valido_q   <= 1'b0;
      repeticoes_q  <= '0;
    end else if (iniciar) begin
      estado_q      <= CAPTURANDO;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ocup_q        <= '0;
      ciclos_q      <= '0;
      escritas_q    <= '0;
      transbordou_q <= 1'b0;
      parado_q      <= 1'b0;
      pc_valido_q   <= 1'b0;
      repeticoes_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q   <= ocup_d;
      if (ocup_d != '0) cabeca_q <= cabeca_d;
      if (descarta || sobrescreve) transbordou_q <= 1'b1;
      if (evt && (escritas_q != '1)) escritas_q <= escritas_q + CNT_W'(1);
      if (capturando) begin
        if (ciclos_q != '1) ciclos_q <= ciclos_q + CNT_W'(1);
        pc_anterior_q <= bus.pc;
        pc_valido_q   <= 1'b1;
        repeticoes_q  <= repeticoes_d;
      end
      case (estado_q)
        CAPTURANDO: begin
          if (!habilitar) begin
            estado_q <= OCIOSO;
          end else if (halt) begin
            estado_q <= PARADO;
            parado_q <= 1'b1;
          end
        end
        PARADO:  if (!habilitar) estado_q <= OCIOSO;
        default: estado_q <= estado_q;
      endcase
    end
  end

  assign bus.saida_valida = (ocup_q != '0);
  assign {bus.saida_pc, bus.saida_rd, bus.saida_dado} = cabeca_q;
  assign ocupacao          = ocup_q;
  assign contador_ciclos   = ciclos_q;
  assign contador_escritas = escritas_q;
  assign transbordou       = transbordou_q;
  assign parado            = parado_q;
endmodule

// File: tb/tb_rastreador_execucao_riscv.sv
// tb/tb_rastreador_execucao_riscv.sv - table-driven and scoreboard bench for the execution tracer
module tb_rastreador_execucao_riscv;
  localparam int XLEN = 32, RA = 5, DEPTH = 16, HALT = 4, CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset_n, habilitar, modo;
  logic [4:0]       ocupacao;
  logic [CNT_W-1:0] cc, ce;
  logic             transbordou, parado;

  rastreador_execucao_riscv_if #(.XLEN(XLEN), .REG_ADDR_W(RA)) bus ();

  rastreador_execucao_riscv #(
    .XLEN(XLEN), .REG_ADDR_W(RA), .DEPTH(DEPTH), .HALT_CYCLES(HALT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .habilitar(habilitar), .modo_sobrescrever(modo),
    .bus(bus), .ocupacao(ocupacao), .contador_ciclos(cc), .contador_escritas(ce),
    .transbordou(transbordou), .parado(parado)
  );

  always #5 clk = ~clk;

  typedef logic [2*XLEN+RA-1:0] ent_t;
  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] dado;
    int          esc;
  } vec_t;

  ent_t        sb[$];
  vec_t        tabela[5];
  int          n_vec = 0, n_err = 0, cyc_exp = 0, esc_exp = 0;
  bit          cap = 0, pend = 0;
  ent_t        pend_ent;
  logic [31:0] pc_ctr = 32'h100;

  task automatic check(input string nome, input logic [127:0] atual, input logic [127:0] esperado);
    n_vec++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
    end
  endtask

  // One clock: compare head against the reference queue, then apply the pending push.
  task automatic tick();
    ent_t h;
    if (cap) cyc_exp++;
    @(negedge clk);
    check("saida_valida", bus.saida_valida, sb.size() != 0);
    if (bus.saida_valida && sb.size() != 0) begin
      h = sb[0];
      check("saida_head", {bus.saida_pc, bus.saida_rd, bus.saida_dado}, h);
      if (bus.saida_pronta) void'(sb.pop_front());
    end
    if (pend) begin
      if (sb.size() == DEPTH) begin
        if (modo) begin
          void'(sb.pop_front());
          sb.push_back(pend_ent);
        end
      end else begin
        sb.push_back(pend_ent);
      end
      pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.pc = pc;
    bus.escrever_registrador = we;
    bus.registrador_destino = rd;
    bus.dados_escrita = d;
    if (cap && we && rd != 0) begin
      pend = 1;
      pend_ent = {pc, rd, d};
      esc_exp++;
    end
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    drive(pc_ctr, we, rd, d);
    pc_ctr += 4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      wb(1'b0, 5'd0, 32'd0);
      tick();
    end
  endtask

  task automatic restart();
    habilitar = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    tick();
    cap = 0;
    habilitar = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    tick();
    sb.delete();
    cyc_exp = 0;
    esc_exp = 0;
    cap = 1;
  endtask

  initial begin
    tabela[0] = '{pc: 32'h0,  we: 1'b1, rd: 5'd1, dado: 32'd5,  esc: 1};
    tabela[1] = '{pc: 32'h4,  we: 1'b1, rd: 5'd2, dado: 32'd7,  esc: 2};
    tabela[2] = '{pc: 32'h8,  we: 1'b1, rd: 5'd0, dado: 32'd9,  esc: 2};
    tabela[3] = '{pc: 32'hc,  we: 1'b0, rd: 5'd3, dado: 32'd1,  esc: 2};
    tabela[4] = '{pc: 32'h10, we: 1'b1, rd: 5'd3, dado: 32'h55, esc: 3};

    reset_n = 1'b0;
    habilitar = 1'b0;
    modo = 1'b0;
    bus.saida_pronta = 1'b1;
    bus.pc = '0;
    bus.escrever_registrador = 1'b0;
    bus.registrador_destino = '0;
    bus.dados_escrita = '0;
    #20;
    check("reset_valida", bus.saida_valida, 1'b0);
    check("reset_ocupacao", ocupacao, 5'd0);
    check("reset_ciclos", cc, 32'd0);
    check("reset_escritas", ce, 32'd0);
    check("reset_transbordou", transbordou, 1'b0);
    check("reset_parado", parado, 1'b0);
    check("reset_dado", bus.saida_dado, 32'd0);
    reset_n = 1'b1;

    // Capture basics and rd=0 filtering
    habilitar = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    tick();
    cap = 1;
    for (int i = 0; i < 5; i++) begin
      drive(tabela[i].pc, tabela[i].we, tabela[i].rd, tabela[i].dado);
      tick();
      check("tabela_escritas", ce, tabela[i].esc);
    end
    idle(2);
    check("tabela_ocupacao", ocupacao, 5'd0);
    check("tabela_transbordou", transbordou, 1'b0);
    check("tabela_ciclos", cc, cyc_exp);

    // Full FIFO, drop mode, then push+pop on full
    restart();
    bus.saida_pronta = 1'b0;
    modo = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      wb(1'b1, 5'(i), 32'(i));
      tick();
    end
    check("drop_ocupacao", ocupacao, 5'd16);
    check("drop_head", bus.saida_dado, 32'd1);
    check("drop_transbordou", transbordou, 1'b1);
    check("drop_escritas", ce, 32'd18);
    bus.saida_pronta = 1'b1;
    wb(1'b1, 5'd5, 32'd100);
    tick();
    bus.saida_pronta = 1'b0;
    check("pushpop_ocupacao", ocupacao, 5'd16);
    check("pushpop_head", bus.saida_dado, 32'd2);

    // Full FIFO, overwrite mode, then drain
    restart();
    modo = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      wb(1'b1, 5'(i), 32'(i));
      tick();
    end
    check("over_ocupacao", ocupacao, 5'd16);
    check("over_head", bus.saida_dado, 32'd3);
    check("over_transbordou", transbordou, 1'b1);
    bus.saida_pronta = 1'b1;
    idle(17);
    check("drain_ocupacao", ocupacao, 5'd0);
    check("drain_hold", bus.saida_dado, 32'd18);
    check("drain_ciclos", cc, cyc_exp);

    // Halt on a stuck PC
    restart();
    modo = 1'b0;
    bus.saida_pronta = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h18, 1'b1, 5'd5, 32'(i + 1));
      tick();
      if (i == 3) check("halt_antes", parado, 1'b0);
    end
    check("halt_parado", parado, 1'b1);
    cap = 0;
    for (int i = 0; i < 3; i++) begin
      wb(1'b1, 5'd6, 32'hdead);
      tick();
    end
    check("halt_ocupacao", ocupacao, 5'd5);
    check("halt_escritas", ce, 32'd5);
    check("halt_ciclos", cc, 32'd5);
    bus.saida_pronta = 1'b1;
    idle(6);
    check("halt_drain", ocupacao, 5'd0);
    check("halt_parado_mantido", parado, 1'b1);
    restart();
    check("rearm_parado", parado, 1'b0);
    check("rearm_ciclos", cc, 32'd0);
    check("rearm_escritas", ce, 32'd0);

    // Asynchronous reset in the middle of a drain
    bus.saida_pronta = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb(1'b1, 5'd7, 32'(i + 40));
      tick();
    end
    bus.saida_pronta = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_valida", bus.saida_valida, 1'b0);
    check("areset_ocupacao", ocupacao, 5'd0);
    check("areset_pc", bus.saida_pc, 32'd0);
    check("areset_rd", bus.saida_rd, 5'd0);
    check("areset_dado", bus.saida_dado, 32'd0);
    check("areset_ciclos", cc, 32'd0);
    sb.delete();
    cap = 0;
    pend = 0;
    habilitar = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    check("pos_reset_ocupacao", ocupacao, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
